// File: rtl/instr_byte_loader.sv
// Instruction byte loader: frames an 8-bit byte stream between FE/FF markers,
// packs big-endian 32-bit words and writes them to consecutive imem addresses.
// The core is held until a complete, correctly terminated program is loaded.
module instr_byte_loader #(
  parameter int unsigned N_WORDS = 64,
  parameter int unsigned AW      = 6
) (
  input  logic          clk_i,
  input  logic          reset_n,
  input  logic [7:0]    instr_i,
  input  logic          byte_valid_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_waddr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          loading_o,
  output logic          cpu_run_o,
  output logic          err_o,
  output logic [AW:0]   words_o
);

  localparam int unsigned WW = AW + 1;
  localparam logic [7:0]    START_BYTE = 8'hFE;
  localparam logic [7:0]    END_BYTE   = 8'hFF;
  localparam logic [WW-1:0] LAST_WORD  = WW'(N_WORDS - 1);
  localparam logic [WW-1:0] MAX_WORDS  = WW'(N_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_END, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [23:0]   part_q, part_d;
  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [31:0]   wdata_d;
  logic          loading_d, run_d, err_d;
  logic [AW:0]   words_d;

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      part_q       <= 24'd0;
      imem_we_o    <= 1'b0;
      imem_waddr_o <= '0;
      imem_wdata_o <= 32'd0;
      loading_o    <= 1'b0;
      cpu_run_o    <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      part_q       <= part_d;
      imem_we_o    <= we_d;
      imem_waddr_o <= waddr_d;
      imem_wdata_o <= wdata_d;
      loading_o    <= loading_d;
      cpu_run_o    <= run_d;
      err_o        <= err_d;
      words_o      <= words_d;
    end
  end

  // Next-state and next-output logic; invalid cycles only drop the strobe.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    part_d    = part_q;
    we_d      = 1'b0;
    waddr_d   = imem_waddr_o;
    wdata_d   = imem_wdata_o;
    loading_d = loading_o;
    run_d     = cpu_run_o;
    err_d     = err_o;
    words_d   = words_o;
    if (byte_valid_i) begin
      case (state_q)
        IDLE: begin
          if (instr_i == START_BYTE) begin
            state_d   = LOAD;
            k_d       = 2'd0;
            words_d   = '0;
            loading_d = 1'b1;
          end
        end
        LOAD: begin
          if (k_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {part_q, instr_i};
            waddr_d = words_o[AW-1:0];
            words_d = (words_o == MAX_WORDS) ? words_o : words_o + WW'(1);
            k_d     = 2'd0;
            if (words_o == LAST_WORD) state_d = WAIT_END;
          end else begin
            part_d = {part_q[15:0], instr_i};
            k_d    = k_q + 2'd1;
          end
        end
        WAIT_END: begin
          loading_d = 1'b0;
          if (instr_i == END_BYTE) begin
            state_d = DONE;
            run_d   = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_byte_loader.md
# instr_byte_loader

Front-end loader that sits directly upstream of the CPU's instruction memory. It receives the 8-bit instruction byte stream, one byte per accepted cycle, framed by a start marker (8'hFE) and an end marker (8'hFF). It packs each group of four payload bytes into a 32-bit instruction word and writes that word into instruction memory at consecutive addresses. It holds the core out of execution until a complete, correctly terminated program has been loaded.

## Interface
- N_WORDS, 64, number of 32-bit instruction words per program (≥1).
- AW, 6, instruction-memory word-address width; must satisfy 2^AW ≥ N_WORDS.

- clk_i  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_i  in  8  instruction byte stream.
- byte_valid_i  in  1  instr_i is valid this cycle; tied high when the stream is continuous.
- imem_we_o  out  1  one-cycle write strobe to instruction memory.
- imem_waddr_o  out  AW  word address of the write.
- imem_wdata_o  out  32  assembled instruction word.
- loading_o  out  1  high from start marker until DONE or ERR.
- cpu_run_o  out  1  high only in DONE; releases the core from hold.
- err_o  out  1  framing error, sticky.
- words_o  out  AW+1  number of words written so far.

## Operation
- Bytes are consumed only on edges where byte_valid_i=1. Cycles with byte_valid_i=0 change nothing except clearing imem_we_o.
- FSM states: IDLE, LOAD, WAIT_END, DONE, ERR.
- IDLE
  - instr_i=8'hFE → LOAD; clear the byte index and words_o.
  - Any other byte is ignored, including 8'hFF.
- LOAD
  - Every byte is payload. 8'hFE and 8'hFF carry no marker meaning here.
  - Byte index k counts 0..3. Byte k goes to bits [31-8k : 24-8k]: the first byte is the MSB (big-endian).
  - On the edge that accepts byte 3:
    - register imem_wdata_o = assembled word;
    - register imem_waddr_o = words_o[AW-1:0];
    - assert imem_we_o;
    - increment words_o;
    - reset k to 0.
  - If that word is number N_WORDS, go to WAIT_END. Otherwise stay in LOAD.
- WAIT_END
  - Next valid byte 8'hFF → DONE.
  - Any other valid byte → ERR.
- DONE: sticky until reset. All bytes ignored. cpu_run_o=1.
- ERR: sticky until reset. err_o=1, cpu_run_o=0. No further writes.
- words_o saturates at N_WORDS and never wraps. imem_waddr_o never exceeds N_WORDS-1.
- An incomplete word (k≠0) is never written.

## Timing
- Reset values (asynchronous on reset_n=0):
  - state=IDLE, k=0;
  - imem_we_o=0, imem_waddr_o=0, imem_wdata_o=0;
  - loading_o=0, cpu_run_o=0, err_o=0, words_o=0.
- Reset mid-load discards any partial word and returns to IDLE. A fresh 8'hFE is required to start again. Memory contents already written are not cleared.
- imem_we_o rises on the same edge that samples byte 3 and is high for exactly one cycle. Addr and data are valid while it is high.
- Back-to-back words with continuous valid produce one write every 4 cycles. There is no minimum gap.
- loading_o rises on the edge that samples 8'hFE. It falls on the edge that enters DONE or ERR.
- cpu_run_o rises on the edge that samples the end marker, which is one valid byte after the last write strobe.
- Full load with continuous valid: the 8'hFE edge, then 4·N_WORDS payload edges, then the end edge. For N_WORDS=64 that is 258 accepted bytes.
- byte_valid_i=0 in the middle of a word stalls k. It does not corrupt the partial word.

## Test plan
- N_WORDS=4, continuous stream 00,00,FE,then 12 34 56 78 / 9A BC DE F0 / FF FF FF FF / 00 00 00 13, then FF.
  - Required: four strobes with (addr,data) = (0,12345678), (1,9ABCDEF0), (2,FFFFFFFF), (3,00000013).
  - cpu_run_o=1 on the edge after the FF marker; err_o=0; words_o=4.
- Same stream with byte_valid_i low for 3 cycles between bytes 2 and 3 of word 1.
  - Required: identical writes; the strobe for word 1 is delayed 3 cycles; no extra strobe.
- N_WORDS=4, four full words followed by 8'h00 instead of FF.
  - Required: err_o=1 and cpu_run_o=0 permanently.
  - A further FE/FF byte produces no writes and no state change.
- N_WORDS=4, FE then 6 payload bytes, then reset_n pulsed low mid-cycle.
  - Required: all outputs 0 immediately (asynchronous), with exactly one write before the reset.
  - A new FE plus 16 bytes plus FF loads addresses 0..3 again.
- Bytes FF, 13, 00 in IDLE, then FE.
  - Required: no writes and loading_o=0 until FE is sampled.
- N_WORDS=64 (default), 258-byte program.
  - Required: 64 strobes at addresses 0..63 with matching data; words_o=64; cpu_run_o=1.
